rom_uploader: RTL and testbench

//  FPGA -> host counterpart of the ZPUFlex boot-data download path: reads bytes from core memory over an

---
 rtl/rom_uploader.sv | 187 ++++++++++++++++++
 tb/tb_rom_uploader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_uploader.sv
// Reads bytes from core memory over an ioctl read port and hands them to the host as big-endian 32-bit words.
// Optional UPLOAD_CHECKSUM_EN adds a 16-bit running sum of the real bytes read this session.
module rom_uploader #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned AW         = 27
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_upload,
  input  logic [15:0]   host_upload_size,
  input  logic          host_upload_req,
  output logic          host_upload_ack,
  output logic [31:0]   host_upload_data,
  output logic          host_upload_done,
  output logic          ioctl_upload,
  output logic [AW-1:0] ioctl_addr,
  output logic          ioctl_rd,
  input  logic [7:0]    ioctl_din,
  output logic [15:0]   upload_checksum
);

  localparam int unsigned IW = 17;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PACK,
    S_READY,
    S_ACKH,
    S_FIN
  } state_t;

  state_t          state_q;
  logic            up_q;
  logic [15:0]     size_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     word_q;
  logic [31:0]     data_q;
  logic            ack_q;
  logic            rd_q;
  logic            done_q;
  logic            ioup_q;
  logic            pad_q;
  logic [CW-1:0]   wait_q;

  logic            session_start;
  logic            real_read;
  logic            all_sent;
  logic [7:0]      pack_byte;
  logic [31:0]     word_d;

  assign session_start = host_upload & ~up_q;
  assign real_read     = (idx_q <= {1'b0, size_q});
  assign all_sent      = (idx_q > {1'b0, size_q});

  // Drop the current byte into its big-endian slot; bytes past the end are zero padding.
  always_comb begin
    pack_byte = pad_q ? 8'h00 : ioctl_din;
    word_d    = word_q;
    case (idx_q[1:0])
      2'd0:    word_d[31:24] = pack_byte;
      2'd1:    word_d[23:16] = pack_byte;
      2'd2:    word_d[15:8]  = pack_byte;
      default: word_d[7:0]   = pack_byte;
    endcase
  end

  // Session control, memory fetch sequencing and host handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      up_q    <= 1'b0;
      size_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      ioup_q  <= 1'b0;
      pad_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      up_q <= host_upload;
      rd_q <= 1'b0;
      if (session_start) begin
        state_q <= S_FETCH;
        size_q  <= host_upload_size;
        idx_q   <= '0;
        addr_q  <= '0;
        word_q  <= '0;
        ack_q   <= 1'b0;
        done_q  <= 1'b0;
        ioup_q  <= 1'b1;
        pad_q   <= 1'b0;
        wait_q  <= '0;
      end else if (!host_upload) begin
        // Aborted session: partial word is simply abandoned, done is left as it was.
        state_q <= S_IDLE;
        ack_q   <= 1'b0;
        ioup_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_FETCH: begin
            if (real_read) begin
              rd_q   <= 1'b1;
              pad_q  <= 1'b0;
              wait_q <= CW'(RD_LATENCY - 1);
            end else begin
              pad_q  <= 1'b1;
              wait_q <= '0;
            end
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_q == '0) begin
              state_q <= S_PACK;
            end else begin
              wait_q <= wait_q - CW'(1);
            end
          end
          S_PACK: begin
            word_q <= word_d;
            idx_q  <= idx_q + IW'(1);
            if (!pad_q) begin
              addr_q <= addr_q + AW'(1);
            end
            state_q <= (idx_q[1:0] == 2'd3) ? S_READY : S_FETCH;
          end
          S_READY: begin
            if (host_upload_req) begin
              ack_q   <= 1'b1;
              data_q  <= word_q;
              state_q <= S_ACKH;
            end
          end
          S_ACKH: begin
            if (!host_upload_req) begin
              ack_q <= 1'b0;
              if (all_sent) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
                ioup_q  <= 1'b0;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
          S_FIN:   state_q <= S_FIN;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0] csum_q;

  // Wrapping sum of the bytes actually read from memory; pad bytes never contribute.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (session_start) begin
      csum_q <= '0;
    end else if (host_upload && up_q && (state_q == S_PACK) && !pad_q) begin
      csum_q <= csum_q + 16'(ioctl_din);
    end
  end

  assign upload_checksum = csum_q;
`else
  assign upload_checksum = 16'h0000;
`endif

  assign host_upload_ack  = ack_q;
  assign host_upload_data = data_q;
  assign host_upload_done = done_q;
  assign ioctl_upload     = ioup_q;
  assign ioctl_addr       = addr_q;
  assign ioctl_rd         = rd_q;

endmodule

// File: tb/tb_rom_uploader.sv
// Bench for rom_uploader: latency-accurate memory model, host req/ack agent and an expected-word queue.
module tb_rom_uploader;

  localparam int unsigned LAT = 3;
  localparam int unsigned AW  = 27;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          host_upload = 1'b0;
  logic [15:0]   host_upload_size = 16'h0000;
  logic          host_upload_req = 1'b0;
  logic          host_upload_ack;
  logic [31:0]   host_upload_data;
  logic          host_upload_done;
  logic          ioctl_upload;
  logic [AW-1:0] ioctl_addr;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;
  logic [15:0]   upload_checksum;

  always #5 clk = ~clk;

  rom_uploader #(.RD_LATENCY(LAT), .AW(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .host_upload      (host_upload),
    .host_upload_size (host_upload_size),
    .host_upload_req  (host_upload_req),
    .host_upload_ack  (host_upload_ack),
    .host_upload_data (host_upload_data),
    .host_upload_done (host_upload_done),
    .ioctl_upload     (ioctl_upload),
    .ioctl_addr       (ioctl_addr),
    .ioctl_rd         (ioctl_rd),
    .ioctl_din        (ioctl_din),
    .upload_checksum  (upload_checksum)
  );

  // Memory returns data only in the cycle LAT cycles after the strobe; garbage otherwise.
  logic [7:0]    mem [0:255];
  logic [7:0]    r_pipe = 8'h00;
  logic [AW-1:0] a_pipe [0:7];

  always @(negedge clk) begin
    for (int i = 7; i > 0; i--) begin
      r_pipe[i] <= r_pipe[i-1];
      a_pipe[i] <= a_pipe[i-1];
    end
    r_pipe[0] <= ioctl_rd;
    a_pipe[0] <= ioctl_addr;
  end

  assign ioctl_din = r_pipe[LAT] ? mem[a_pipe[LAT][7:0]] : 8'hA5;

  int            n_vec = 0;
  int            n_err = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic          rd_prev = 1'b0;
  logic [31:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Every read strobe must be a single cycle and walk the addresses upward from 0.
  always @(negedge clk) begin
    if (ioctl_rd) begin
      check("rd_addr", 32'(ioctl_addr), 32'(rd_cnt));
      check("rd_single", 32'(rd_prev), 32'd0);
      rd_cnt++;
      last_addr = ioctl_addr;
    end
    rd_prev = ioctl_rd;
  end

  typedef struct {
    int           size;
    logic [127:0] bytes;
    bit           req_early;
    int           hold;
    logic [15:0]  csum;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [7:0] get_byte(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  task automatic load(input vec_t v);
    logic [31:0] w;
    for (int i = 0; i < 256; i++) mem[i] = (i <= v.size && i < 16) ? get_byte(v.bytes, i) : 8'h77;
    for (int k = 0; k <= (v.size >> 2); k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        if (4*k + j <= v.size) w[31-8*j -: 8] = get_byte(v.bytes, 4*k + j);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic run_session(input vec_t v);
    int          nw;
    int          t;
    int          exp_rd;
    logic [31:0] exp_w;
    logic [15:0] exp_cs;
    nw = (v.size >> 2) + 1;
    load(v);
    rd_cnt = 0;
    host_upload_size = 16'(v.size);
    host_upload = 1'b1;
    host_upload_req = v.req_early;
    for (int k = 0; k < nw; k++) begin
      if (!v.req_early) begin
        repeat (30) @(negedge clk);
        check("ack_before_req", 32'(host_upload_ack), 32'd0);
      end
      host_upload_req = 1'b1;
      t = 0;
      while (!host_upload_ack && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (!host_upload_ack) begin
        check("ack_timeout", 32'd0, 32'd1);
        host_upload_req = 1'b0;
        host_upload = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        return;
      end
      exp_w = exp_q.pop_front();
      check("word", host_upload_data, exp_w);
      exp_rd = (4*(k+1) < v.size + 1) ? 4*(k+1) : v.size + 1;
      check("reads_at_ack", 32'(rd_cnt), 32'(exp_rd));
      repeat (v.hold) begin
        @(negedge clk);
        check("ack_hold", 32'(host_upload_ack), 32'd1);
        check("data_hold", host_upload_data, exp_w);
      end
      host_upload_req = 1'b0;
      @(negedge clk);
      check("ack_release", 32'(host_upload_ack), 32'd0);
      check("done_flag", 32'(host_upload_done), (k == nw - 1) ? 32'd1 : 32'd0);
    end
    check("rd_total", 32'(rd_cnt), 32'(v.size + 1));
    check("last_addr", 32'(last_addr), 32'(v.size));
    check("ioctl_upload_off", 32'(ioctl_upload), 32'd0);
`ifdef UPLOAD_CHECKSUM_EN
    exp_cs = v.csum;
`else
    exp_cs = 16'h0000;
`endif
    check("checksum", 32'(upload_checksum), 32'(exp_cs));
    host_upload = 1'b0;
    repeat (2) @(negedge clk);
    check("done_kept", 32'(host_upload_done), 32'd1);
    check("ack_idle", 32'(host_upload_ack), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(host_upload_ack), 32'd0);
    check({tag, "_data"}, host_upload_data, 32'd0);
    check({tag, "_done"}, 32'(host_upload_done), 32'd0);
    check({tag, "_ioctl_upload"}, 32'(ioctl_upload), 32'd0);
    check({tag, "_addr"}, 32'(ioctl_addr), 32'd0);
    check({tag, "_rd"}, 32'(ioctl_rd), 32'd0);
    check({tag, "_checksum"}, 32'(upload_checksum), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vecs[0] = '{7,  128'h01020304050607080000000000000000, 1'b0, 2, 16'h0024};
    vecs[1] = '{4,  128'hAABBCCDDEE0000000000000000000000, 1'b0, 1, 16'h03FC};
    vecs[2] = '{2,  128'hFFFF0200000000000000000000000000, 1'b1, 0, 16'h0200};
    vecs[3] = '{0,  128'h5A000000000000000000000000000000, 1'b1, 3, 16'h005A};
    vecs[4] = '{11, 128'h101112131415161718191A1B00000000, 1'b1, 1, 16'h0102};
    vecs[5] = '{3,  128'h80818283000000000000000000000000, 1'b0, 0, 16'h0206};
    vecs[6] = '{15, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b0, 1, 16'h0F78};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_session(vecs[i]);
      @(negedge clk);
    end

    // Session abandoned right after the first word is acknowledged.
    load(vecs[6]);
    rd_cnt = 0;
    host_upload_size = 16'd15;
    host_upload = 1'b1;
    host_upload_req = 1'b1;
    t = 0;
    while (!host_upload_ack && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drop_first_ack", 32'(host_upload_ack), 32'd1);
    check("drop_word", host_upload_data, exp_q.pop_front());
    host_upload = 1'b0;
    @(negedge clk);
    check("drop_ack_low", 32'(host_upload_ack), 32'd0);
    check("drop_ioctl_upload", 32'(ioctl_upload), 32'd0);
    host_upload_req = 1'b0;
    repeat (20) @(negedge clk);
    check("drop_no_reads", 32'(rd_cnt), 32'd4);
    check("drop_done", 32'(host_upload_done), 32'd0);
    exp_q.delete();

    // Reset hits while a read is outstanding.
    load(vecs[0]);
    rd_cnt = 0;
    host_upload_size = 16'd7;
    host_upload = 1'b1;
    t = 0;
    while (!ioctl_rd && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_rd_seen", 32'(ioctl_rd), 32'd1);
    reset = 1'b1;
    host_upload = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    exp_q.delete();
    repeat (6) @(negedge clk);
    run_session(vecs[0]);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
